// File: rtl/bus_pkg.sv
// Shared types and default constants for the bus responder slice.
package bus_pkg;

  localparam int          DEFAULT_DATA_WIDTH = 32;
  localparam int          DEFAULT_ADDR_WIDTH = 4;
  localparam logic [31:0] DEFAULT_ID_VALUE   = 32'hB0B0_0001;
  localparam int          CNT_WIDTH          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_responder_regfile.sv
// Register storage with one write port and a combinational read mux.
// Address 0 is a read-only ID word; it has no writable storage behind it.
module bus_responder_regfile
  import bus_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DEFAULT_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr == '0) ? ID_VALUE : regs[rd_addr];

endmodule

// File: rtl/bus_responder.sv
// Simple register-bank bus target: req/ack handshake with programmable wait
// states, read-only ID at address 0 and a sticky protocol-error flag.
module bus_responder
  import bus_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  rnw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  proto_err
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

  state_t                state;
  state_t                next_state;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [CNT_WIDTH-1:0]  next_cnt;
  logic                  abort;
  logic                  enter_ack;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            next_state = WAIT;
            next_cnt   = WAIT_LOAD;
          end else begin
            next_state = ACK;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          next_state = IDLE;
          next_cnt   = '0;
          abort      = 1'b1;
        end else if (wait_cnt == '0) begin
          next_state = ACK;
        end else begin
          next_cnt = wait_cnt - 1'b1;
        end
      end
      ACK: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Everything about a transfer (write, read data, err) is committed on the
  // edge that enters ACK, using the fields sampled on that edge.
  assign enter_ack = (next_state == ACK);
  assign wr_en     = rst_n && enter_ack && !rnw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      ack      <= enter_ack;
      err      <= enter_ack && !rnw && (addr == '0);
      rdata    <= (enter_ack && rnw) ? rd_data : '0;
      if (abort) begin
        proto_err <= 1'b1;
      end
    end
  end

  bus_responder_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (addr),
    .wr_data (wdata),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench: three responders (WAIT_CYCLES 2, 0, 3) driven by
// directed and random transfers, checked against an array-based model.
module tb_bus_responder;

  localparam logic [31:0] ID_WORD = 32'hB0B0_0001;

  logic        clk;
  logic        rst_n_v [3];
  logic        req_v   [3];
  logic        rnw_v   [3];
  logic [3:0]  addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        ack_v   [3];
  logic        err_v   [3];
  logic [31:0] rdata_v [3];
  logic        proto_v [3];

  int          wc_of [3] = '{2, 0, 3};
  logic [31:0] model_regs  [3][16];
  logic        model_proto [3];

  int checks = 0;
  int errors = 0;

  bus_responder #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .rnw(rnw_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .ack(ack_v[0]), .err(err_v[0]),
    .rdata(rdata_v[0]), .proto_err(proto_v[0]));

  bus_responder #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .rnw(rnw_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ack(ack_v[1]), .err(err_v[1]),
    .rdata(rdata_v[1]), .proto_err(proto_v[1]));

  bus_responder #(.WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .req(req_v[2]), .rnw(rnw_v[2]),
    .addr(addr_v[2]), .wdata(wdata_v[2]), .ack(ack_v[2]), .err(err_v[2]),
    .rdata(rdata_v[2]), .proto_err(proto_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(int d, string tag);
    check_output($sformatf("%s ack d%0d", tag, d), 32'(ack_v[d]), 32'd0);
    check_output($sformatf("%s err d%0d", tag, d), 32'(err_v[d]), 32'd0);
    check_output($sformatf("%s rdata d%0d", tag, d), rdata_v[d], 32'd0);
    check_output($sformatf("%s proto d%0d", tag, d), 32'(proto_v[d]), 32'(model_proto[d]));
  endtask

  task automatic model_clear(int d);
    for (int i = 0; i < 16; i++) model_regs[d][i] = 32'd0;
    model_proto[d] = 1'b0;
  endtask

  // One complete transfer, entered and left on a falling edge.
  task automatic apply_stimulus(int d, bit r, logic [3:0] a, logic [31:0] wd, bit keep);
    int lat;
    bit seen;
    logic [31:0] exp_rdata;
    logic        exp_err;
    rnw_v[d] = r; addr_v[d] = a; wdata_v[d] = wd; req_v[d] = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (ack_v[d]) seen = 1;
      else begin
        check_output($sformatf("wait rdata d%0d", d), rdata_v[d], 32'd0);
        lat++;
      end
    end
    check_output($sformatf("latency d%0d a%0d", d, a), 32'(lat), 32'(wc_of[d]));
    exp_err   = !r && (a == 4'd0);
    exp_rdata = r ? ((a == 4'd0) ? ID_WORD : model_regs[d][a]) : 32'd0;
    check_output($sformatf("err d%0d a%0d", d, a), 32'(err_v[d]), 32'(exp_err));
    check_output($sformatf("rdata d%0d a%0d", d, a), rdata_v[d], exp_rdata);
    check_output($sformatf("proto d%0d", d), 32'(proto_v[d]), 32'(model_proto[d]));
    if (!r && a != 4'd0) model_regs[d][a] = wd;
    if (!keep) req_v[d] = 1'b0;
    @(negedge clk);
    check_output($sformatf("ack one cycle d%0d", d), 32'(ack_v[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  a;
    bit          r;
    for (int d = 0; d < 3; d++) begin
      rst_n_v[d] = 1'b0; req_v[d] = 1'b0; rnw_v[d] = 1'b0;
      addr_v[d] = 4'd0; wdata_v[d] = 32'd0;
      model_clear(d);
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_quiet(d, "reset");
    for (int d = 0; d < 3; d++) rst_n_v[d] = 1'b1;
    @(negedge clk);

    $display("[TB] directed: write/read with 2 wait states");
    apply_stimulus(0, 1'b0, 4'd3, 32'hDEAD_BEEF, 1'b0);
    apply_stimulus(0, 1'b1, 4'd3, 32'd0, 1'b0);
    apply_stimulus(0, 1'b1, 4'd0, 32'd0, 1'b0);
    apply_stimulus(0, 1'b0, 4'd0, 32'h0000_1234, 1'b0);
    apply_stimulus(0, 1'b1, 4'd0, 32'd0, 1'b0);

    $display("[TB] directed: back-to-back writes with 0 wait states");
    for (int i = 1; i <= 4; i++)
      apply_stimulus(1, 1'b0, 4'(i), 32'hA5A5_0000 + 32'(i), (i != 4));
    for (int i = 1; i <= 4; i++)
      apply_stimulus(1, 1'b1, 4'(i), 32'd0, 1'b1);
    req_v[1] = 1'b0;
    @(negedge clk);

    $display("[TB] directed: req dropped during wait");
    apply_stimulus(2, 1'b0, 4'd6, 32'h1111_2222, 1'b0);
    wd = $urandom;
    rnw_v[2] = 1'b0; addr_v[2] = 4'd6; wdata_v[2] = wd; req_v[2] = 1'b1;
    @(negedge clk);
    check_output("abort ack before drop", 32'(ack_v[2]), 32'd0);
    req_v[2] = 1'b0;
    model_proto[2] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_quiet(2, "after abort");
    end
    apply_stimulus(2, 1'b1, 4'd6, 32'd0, 1'b0);
    apply_stimulus(2, 1'b1, 4'd0, 32'd0, 1'b0);
    rst_n_v[2] = 1'b0;
    model_clear(2);
    @(negedge clk);
    check_quiet(2, "proto cleared by reset");
    rst_n_v[2] = 1'b1;
    @(negedge clk);

    $display("[TB] directed: reset during wait of a write");
    rnw_v[0] = 1'b0; addr_v[0] = 4'd5; wdata_v[0] = 32'hCAFE_F00D; req_v[0] = 1'b1;
    @(negedge clk);
    rst_n_v[0] = 1'b0; req_v[0] = 1'b0;
    model_clear(0);
    @(negedge clk);
    check_quiet(0, "reset mid-wait");
    rst_n_v[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_quiet(0, "after reset");
    end
    apply_stimulus(0, 1'b1, 4'd5, 32'd0, 1'b0);
    apply_stimulus(0, 1'b1, 4'd3, 32'd0, 1'b0);

    $display("[TB] random transfers");
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        r  = 1'($urandom_range(0, 1));
        a  = 4'($urandom_range(0, 15));
        wd = $urandom;
        apply_stimulus(d, r, a, wd, 1'($urandom_range(0, 1)));
      end
      req_v[d] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) apply_stimulus(d, 1'b1, 4'(i), 32'd0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of wdata/rdata and of each register.
REQ-002 Parameter: ADDR_WIDTH, 4, word address width; register count = 2**ADDR_WIDTH.
REQ-003 Parameter: WAIT_CYCLES, 2, wait states inserted before ack (0..15 legal).
REQ-004 Parameter: ID_VALUE, 32'hB0B0_0001, read-only content of address 0.
REQ-005 Port: clk input 1, single clock; all logic on rising edge.
REQ-006 Port: rst_n input 1, reset, synchronous, active-low.
REQ-007 Port: req input 1, initiator transfer request; held high until ack.
REQ-008 Port: rnw input 1, 1 = read, 0 = write; stable while req high.
REQ-009 Port: addr input ADDR_WIDTH, word address; stable while req high.
REQ-010 Port: wdata input DATA_WIDTH, write data; stable while req high.
REQ-011 Port: ack output 1, transfer complete; high exactly one cycle per transfer.
REQ-012 Port: err output 1, transfer error; valid only while ack high, else 0.
REQ-013 Port: rdata output DATA_WIDTH, read data; valid only while ack high with rnw=1, else 0.
REQ-014 Port: proto_err output 1, sticky flag: initiator dropped req before ack.

Function
REQ-015 FSM states: IDLE, WAIT, ACK.
REQ-016 IDLE: req=1 sampled -> WAIT when WAIT_CYCLES>0, else -> ACK; req=0 -> stay IDLE.
REQ-017 WAIT: down-counter loaded with WAIT_CYCLES-1 on entry; counter=0 with req=1 -> ACK; decrement otherwise.
REQ-018 Latency: req sampled at edge N -> ack high in cycle N+1+WAIT_CYCLES.
REQ-019 ACK: ack=1 for one cycle, then unconditionally -> IDLE; minimum transfer period 2 cycles with WAIT_CYCLES=0.
REQ-020 Back-to-back: req held high after ack with new fields -> a new transfer starts from the IDLE cycle; no extra gap.
REQ-021 Read: rdata = register[addr] (ID_VALUE at addr 0), registered on the edge entering ACK.
REQ-022 Write to addr 1..max: register updated on the edge entering ACK; new value readable by the next transfer.
REQ-023 Write to addr 0: no storage change; err=1 with ack.
REQ-024 Read of any address, and write to a nonzero address: err=0.
REQ-025 req=0 sampled in WAIT: abort -> IDLE, no write, no ack, proto_err set to 1 and held until reset.
REQ-026 Changes to addr/rnw/wdata while in WAIT are not detected; the values sampled on the edge entering ACK are used.

Reset
REQ-027 rst_n=0 at a rising edge: FSM -> IDLE; ack, err, rdata, proto_err -> 0; wait counter -> 0.
REQ-028 Registers 1..max reset to 0.
REQ-029 Reset mid-transfer (WAIT or ACK) discards the transfer: no write, no ack in the cycle after reset.

Structure
REQ-030 Package bus_pkg holds the state enum (IDLE/WAIT/ACK) and the default DATA_WIDTH, ADDR_WIDTH and ID_VALUE constants.
REQ-031 Sub-module bus_responder_regfile holds storage, the write port and the combinational read mux; the FSM, counter and outputs stay in bus_responder.

Verification
REQ-032 WAIT_CYCLES=2; write addr 3 data 32'hDEAD_BEEF, then read addr 3 -> each ack arrives 3 cycles after req is sampled; rdata=32'hDEAD_BEEF; err=0.
REQ-033 Read addr 0 -> rdata=32'hB0B0_0001, err=0; write addr 0 data 32'h1234 -> err=1; subsequent read addr 0 -> still 32'hB0B0_0001.
REQ-034 WAIT_CYCLES=0; req held high for 4 back-to-back writes to addr 1..4 -> ack on alternate cycles (4 acks in 8 cycles); readback matches.
REQ-035 req dropped 1 cycle into WAIT (WAIT_CYCLES=3) -> no ack, target register unchanged, proto_err=1 until rst_n=0.
REQ-036 rst_n=0 asserted during WAIT of a write to addr 5 -> no ack follows; all outputs 0 in the cycle after reset; read addr 5 returns 0.
